// File: rtl/serializador_entrada_pkg.sv
// -----------------------------------------------------------------------------
// serializador_pkg
//
// Shared definitions for the serializador_entrada slice:
//   - estado_t          : FSM state encoding (OCIOSO, DESLOCA, PARIDADE)
//   - largura_contador  : width of the bit-index counter for a given word width
//
// PARIDADE is only ever entered when SERIALIZADOR_PARIDADE_EN is defined.
// The encoding is kept identical in both builds so that checkers bound to
// the debug state output do not depend on the build option.
// -----------------------------------------------------------------------------
package serializador_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,  // idle, line held at zero
    DESLOCA  = 2'd1,  // shifting data bits
    PARIDADE = 2'd2   // appended even-parity bit
  } estado_t;

  // The counter must also be able to hold LARGURA, which is the index
  // of the parity bit, hence LARGURA+1 distinct values.
  function automatic int largura_contador(input int largura);
    return $clog2(largura + 1);
  endfunction

endpackage : serializador_pkg

// File: rtl/serializador_entrada_registrador_deslocamento.sv
// -----------------------------------------------------------------------------
// registrador_deslocamento
//
// Loadable shift register used by serializador_entrada to emit a parallel
// word one bit per clock.
//
// Parameters:
//   LARGURA   : word width (>= 2)
//   ORDEM_MSB : 1 = bit LARGURA-1 is presented first and the register
//               shifts towards the MSB; 0 = bit 0 first, shifts towards LSB
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-low reset (clears the register)
//   carrega      in   load dado into the register at the next edge
//   desloca      in   shift by one position at the next edge
//   dado         in   parallel word to load
//   saida_serial out  bit currently at the output end of the register
//
// Load has priority over shift: when a new word is accepted during the
// final bit of the previous word, the register must pick up the new word
// rather than shift out a stale zero.
// -----------------------------------------------------------------------------
module registrador_deslocamento #(
  parameter int LARGURA   = 8,
  parameter bit ORDEM_MSB = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               carrega,
  input  logic               desloca,
  input  logic [LARGURA-1:0] dado,
  output logic               saida_serial
);

  logic [LARGURA-1:0] reg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q <= '0;
    end else if (carrega) begin
      reg_q <= dado;
    end else if (desloca) begin
      if (ORDEM_MSB) begin
        reg_q <= {reg_q[LARGURA-2:0], 1'b0};
      end else begin
        reg_q <= {1'b0, reg_q[LARGURA-1:1]};
      end
    end
  end

  assign saida_serial = ORDEM_MSB ? reg_q[LARGURA-1] : reg_q[0];

endmodule : registrador_deslocamento

// File: rtl/serializador_entrada.sv
// -----------------------------------------------------------------------------
// serializador_entrada
//
// Parallel-to-serial stage feeding the 1-bit 'entrada' input of the
// downstream sequence machine (maquuina_estados). A LARGURA-bit word is
// accepted through a valid/ready handshake and shifted out one bit per
// clock. Idle cycles drive a steady zero on the serial line.
//
// Build option:
//   SERIALIZADOR_PARIDADE_EN  when defined, an even-parity bit is appended
//                             after the data bits of every word (LARGURA+1
//                             bits per word, ultimo_bit on the parity bit).
//
// Parameters:
//   LARGURA   : data word width (>= 2)
//   ORDEM_MSB : 1 = MSB first, 0 = LSB first
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous, active-low reset
//   dado           in   parallel word, sampled only at handshake
//   dado_valido    in   word offered on dado
//   pronto         out  block can accept a word this cycle
//   entrada_serial out  serial bit to downstream 'entrada'
//   bit_valido     out  entrada_serial carries a word/parity bit
//   ultimo_bit     out  current bit is the final bit of the word
//   contador_bits  out  index of the bit on the line; 0 when idle
//   rst_jusante    out  active-high reset for the downstream machine (~rst)
//   estado_dbg     out  current FSM state, for observation only
//
// Handshake (valid/ready):
//   A word transfers at a rising edge where dado_valido && pronto. dado is
//   copied into the shift register at that edge, and the first bit appears
//   on entrada_serial in the following cycle. dado_valido while pronto is
//   low is ignored, and dado is don't-care outside the transfer edge.
//   pronto is combinational from state: high when idle and during the last
//   bit of a word (which allows zero-gap back-to-back words), and forced low
//   while rst is asserted.
//
// entrada_serial, bit_valido, ultimo_bit and contador_bits are decoded
// purely from registers, so they have no combinational path from inputs.
// -----------------------------------------------------------------------------
module serializador_entrada
  import serializador_pkg::*;
#(
  parameter int LARGURA   = 8,
  parameter bit ORDEM_MSB = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LARGURA-1:0]             dado,
  input  logic                           dado_valido,
  output logic                           pronto,
  output logic                           entrada_serial,
  output logic                           bit_valido,
  output logic                           ultimo_bit,
  output logic [$clog2(LARGURA+1)-1:0]   contador_bits,
  output logic                           rst_jusante,
  output estado_t                        estado_dbg
);

  localparam int            CW         = largura_contador(LARGURA);
  localparam logic [CW-1:0] CNT_ULTIMO = CW'(LARGURA - 1);

  estado_t       estado_q;
  estado_t       estado_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic          aceita;      // handshake completes at the next edge
  logic          fim_dados;   // last data bit is on the line
  logic          ultimo;      // last bit of the word (data or parity)
  logic          sr_saida;    // serial output of the shift register
  logic          par_bit;     // parity bit of the word in flight

  // ---------------------------------------------------------------------------
  // Datapath: shift register
  // ---------------------------------------------------------------------------
  registrador_deslocamento #(
    .LARGURA   (LARGURA),
    .ORDEM_MSB (ORDEM_MSB)
  ) u_registrador (
    .clk          (clk),
    .rst          (rst),
    .carrega      (aceita),
    .desloca      (estado_q == DESLOCA),
    .dado         (dado),
    .saida_serial (sr_saida)
  );

`ifdef SERIALIZADOR_PARIDADE_EN
  // Parity is captured from the word at the handshake so that later
  // changes on dado cannot affect the emitted parity bit.
  logic par_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (aceita) begin
      par_q <= ^dado;
    end
  end

  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and end-of-word decode
  // ---------------------------------------------------------------------------
  assign fim_dados = (estado_q == DESLOCA) && (cnt_q == CNT_ULTIMO);

`ifdef SERIALIZADOR_PARIDADE_EN
  assign ultimo = (estado_q == PARIDADE);
`else
  assign ultimo = fim_dados;
`endif

  // rst gates pronto directly so it drops during reset without a clock.
  assign pronto = rst && ((estado_q == OCIOSO) || ultimo);
  assign aceita = dado_valido && pronto;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;

    case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          estado_d = DESLOCA;
          cnt_d    = '0;
        end
      end

      DESLOCA: begin
        if (fim_dados) begin
`ifdef SERIALIZADOR_PARIDADE_EN
          estado_d = PARIDADE;
          cnt_d    = CW'(LARGURA);
`else
          // A word accepted on the last bit starts shifting with no gap.
          if (aceita) begin
            estado_d = DESLOCA;
            cnt_d    = '0;
          end else begin
            estado_d = OCIOSO;
            cnt_d    = '0;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PARIDADE: begin
        // Exit identical to the last data bit of a build without parity.
        if (aceita) begin
          estado_d = DESLOCA;
          cnt_d    = '0;
        end else begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end
      end

      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    entrada_serial = 1'b0;
    bit_valido     = 1'b0;
    case (estado_q)
      DESLOCA: begin
        entrada_serial = sr_saida;
        bit_valido     = 1'b1;
      end
      PARIDADE: begin
        entrada_serial = par_bit;
        bit_valido     = 1'b1;
      end
      default: begin
        entrada_serial = 1'b0;
        bit_valido     = 1'b0;
      end
    endcase
  end

  assign ultimo_bit    = ultimo;
  assign contador_bits = cnt_q;
  assign rst_jusante   = ~rst;
  assign estado_dbg    = estado_q;

endmodule : serializador_entrada
